cdb_arbiter: RTL and testbench

- Schedules functional-unit results onto the single common data bus (CDB) that feeds the reorder buffer and reservation stations.
- Six producers compete for the bus: LS, ADD1, ADD2, ADD3, MULT1, MULT2.
- Grants at most one producer per cycle using round-robin priority.
- Drives a registered CDB beat (valid, data, producer tag) one cycle after the grant. The ROB matches this tag against its waiting-for field.

---
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter that schedules six functional-unit results
//               onto the common data bus as a registered one-cycle beat.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int N_REQ  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [2:0]              ls_idx,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [2:0]              grant_idx
);

    localparam logic [2:0] c_NO_GRANT = 3'd7;
    localparam logic [2:0] c_LAST_REQ = 3'd5;

    logic [2:0]        r_ptr;
    logic [N_REQ-1:0]  w_grant_oh;
    logic [2:0]        w_grant_idx;
    logic              w_found;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;
    logic [TAG_W-1:0]  w_tag;

    // Circular scan starting at r_ptr; first valid requester wins.
    always_comb begin
        logic [3:0] w_sum;
        logic [2:0] w_pos;
        w_grant_oh  = '0;
        w_grant_idx = c_NO_GRANT;
        w_found     = 1'b0;
        w_sum       = '0;
        w_pos       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            w_pos = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
            if (!w_found && req_valid[w_pos]) begin
                w_found            = 1'b1;
                w_grant_idx        = w_pos;
                w_grant_oh[w_pos]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // LS tags follow the buffer slot (1..6); the other units have fixed tags 7..11.
    always_comb begin
        if (w_grant_idx == 3'd0) begin
            w_tag = TAG_W'(ls_idx) + TAG_W'(1);
        end else begin
            w_tag = TAG_W'(w_grant_idx) + TAG_W'(6);
        end
    end

    assign w_xfer    = w_found && !rst && !flush;
    assign req_ready = w_xfer ? w_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ptr     <= 3'd0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            grant_idx <= c_NO_GRANT;
        end else if (w_xfer) begin
            r_ptr     <= (w_grant_idx == c_LAST_REQ) ? 3'd0 : w_grant_idx + 3'd1;
            cdb_valid <= 1'b1;
            cdb_data  <= w_data;
            cdb_tag   <= w_tag;
            grant_idx <= w_grant_idx;
        end else begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            grant_idx <= c_NO_GRANT;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter; directed cases followed
//               by randomized held requests against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int N_REQ  = 6;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [2:0]              ls_idx = '0;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [DATA_W-1:0]       cdb_data;
    logic [TAG_W-1:0]        cdb_tag;
    logic [2:0]              grant_idx;

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;
    int g_last;
    logic [N_REQ-1:0] pending;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .ls_idx    (ls_idx),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_tag   (cdb_tag),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round robin: first valid requester walking ptr, ptr+1, ... modulo 6.
    function automatic int model_grant(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // One clock: apply rst/flush, check the combinational grant, then the beat.
    task automatic cycle(input logic rst_v, input logic flush_v, output int g_out);
        int          g;
        logic [63:0] e_ready;
        logic        e_valid;
        logic [63:0] e_data;
        logic [63:0] e_tag;
        logic [63:0] e_gidx;
        rst   = rst_v;
        flush = flush_v;
        @(negedge clk);
        g = model_grant(req_valid, m_ptr);
        e_ready = (rst_v || flush_v || g < 0) ? 64'd0 : (64'd1 << g);
        check("req_ready", 64'(req_ready), e_ready);
        if (rst_v || flush_v || g < 0) begin
            e_valid = 1'b0;
            e_data  = 0;
            e_tag   = 0;
            e_gidx  = 7;
            if (rst_v || flush_v) m_ptr = 0;
            g_out = -1;
        end else begin
            e_valid = 1'b1;
            e_data  = 64'(req_data[g*DATA_W +: DATA_W]);
            e_tag   = (g == 0) ? 64'((int'(ls_idx) + 1) % 16) : 64'(g + 6);
            e_gidx  = 64'(g);
            m_ptr   = (g + 1) % N_REQ;
            g_out   = g;
        end
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check("cdb_data",  64'(cdb_data),  e_data);
        check("cdb_tag",   64'(cdb_tag),   e_tag);
        check("grant_idx", 64'(grant_idx), e_gidx);
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        // Reset state
        cycle(1'b1, 1'b0, g_last);
        check("reset_gidx", 64'(grant_idx), 64'd7);

        // ADD2 alone
        req_valid = 6'b000100;
        set_data(2, 32'h0000_00AA);
        cycle(1'b0, 1'b0, g_last);
        check("add2_tag", 64'(cdb_tag), 64'd8);
        check("add2_data", 64'(cdb_data), 64'hAA);

        // ptr = 3: MULT2 ahead of ADD1
        req_valid = 6'b100010;
        set_data(5, 32'h5555_0005);
        set_data(1, 32'h1111_0001);
        cycle(1'b0, 1'b0, g_last);
        check("mult2_first", 64'(cdb_tag), 64'd11);
        req_valid = 6'b000010;
        cycle(1'b0, 1'b0, g_last);
        check("add1_second", 64'(cdb_tag), 64'd7);
        // ptr now 2: ADD2 beats LS
        req_valid = 6'b000101;
        cycle(1'b0, 1'b0, g_last);
        check("ptr_after_add1", 64'(grant_idx), 64'd2);

        // LS with buffer index 4
        req_valid = 6'b000001;
        ls_idx = 3'd4;
        set_data(0, 32'h0000_1234);
        cycle(1'b0, 1'b0, g_last);
        check("ls_tag", 64'(cdb_tag), 64'd5);
        check("ls_data", 64'(cdb_data), 64'h1234);

        // All six held for 12 cycles from reset: strict rotation
        req_valid = '0;
        cycle(1'b1, 1'b0, g_last);
        req_valid = 6'b111111;
        for (int i = 0; i < N_REQ; i++) set_data(i, 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, g_last);
            check("rot_gidx", 64'(grant_idx), 64'(i % 6));
            check("rot_valid", 64'(cdb_valid), 64'd1);
        end

        // Flush on a MULT1 grant, then MULT1 granted the next cycle
        req_valid = 6'b000000;
        cycle(1'b1, 1'b0, g_last);
        req_valid = 6'b010000;
        set_data(4, 32'hDEAD_0004);
        cycle(1'b0, 1'b1, g_last);
        check("flush_valid", 64'(cdb_valid), 64'd0);
        cycle(1'b0, 1'b0, g_last);
        check("post_flush_gidx", 64'(grant_idx), 64'd4);

        // Reset the cycle after a grant
        req_valid = 6'b001000;
        set_data(3, 32'hBEEF_0003);
        cycle(1'b0, 1'b0, g_last);
        req_valid = '0;
        cycle(1'b1, 1'b0, g_last);
        check("rst_drop_valid", 64'(cdb_valid), 64'd0);
        req_valid = 6'b100001;
        cycle(1'b0, 1'b0, g_last);
        check("rst_ptr0_gidx", 64'(grant_idx), 64'd0);

        // Randomized held requests with occasional drop, flush and reset
        req_valid = '0;
        pending   = '0;
        g_last    = -1;
        for (int n = 0; n < 600; n++) begin
            logic r_v;
            logic f_v;
            for (int i = 0; i < N_REQ; i++) begin
                if (pending[i] && g_last == i) begin
                    pending[i] = 1'b0;
                end
                if (!pending[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pending[i] = 1'b1;
                        set_data(i, $urandom);
                        if (i == 0) ls_idx = 3'($urandom_range(7));
                    end
                end else if ($urandom_range(15) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            req_valid = pending;
            r_v = ($urandom_range(59) == 0);
            f_v = ($urandom_range(19) == 0);
            cycle(r_v, f_v, g_last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
